// File: rtl/la_nordet.sv
// la_nordet: registered N-input NOR detector with hold-time qualification,
// rise/fall pulses and a saturating event counter. Optional macro: LA_NORDET_STICKY_EN (sticky 'seen' flag).
module la_nordet #(
    parameter int N    = 4,
    parameter int HOLD = 4,
    parameter int CW   = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          en,
    input  logic          clear,
    input  logic [N-1:0]  in,
    output logic          z,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] evcnt,
    output logic          seen
);

    localparam int            HW        = $clog2(HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0] CNT_ONE   = HW'(1);
    localparam logic [HW-1:0] CNT_ZERO  = {HW{1'b0}};
    localparam logic [CW-1:0] EV_ONE    = CW'(1);
    localparam logic [CW-1:0] EV_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] EV_MAX    = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_QUAL   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // PROP carries no behaviour; both branches are intentionally empty.
    if (PROP == "DEFAULT") begin : g_prop_default
    end else begin : g_prop_custom
    end

    state_t        state_r, state_s;
    logic [HW-1:0] cnt_r, cnt_s;
    logic [N-1:0]  in_q_r;
    logic          z_r, rise_r, fall_r;
    logic [CW-1:0] evcnt_r, evcnt_s;
    logic          raw_s, enter_s, leave_s;

    assign raw_s = ~|in_q_r;

    // Input sampling register; resets to all-ones so nothing qualifies out of reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            in_q_r <= {N{1'b1}};
        end else begin
            in_q_r <= in;
        end
    end

    // Next-state and hold-counter logic of the qualification FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            S_IDLE: begin
                if (en && raw_s) begin
                    if (HOLD == 1) begin
                        state_s = S_ACTIVE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = S_QUAL;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    state_s = S_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            S_QUAL: begin
                if (en && raw_s) begin
                    if (cnt_r == HOLD_LAST) begin
                        state_s = S_ACTIVE;
                        cnt_s   = CNT_ZERO;
                    end else begin
                        state_s = S_QUAL;
                        cnt_s   = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_s = S_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            S_ACTIVE: begin
                if (en && raw_s) begin
                    state_s = S_ACTIVE;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = S_IDLE;
                    cnt_s   = CNT_ZERO;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Transition decode; a drop caused by en=0 is not a qualified fall.
    always_comb begin
        enter_s = (state_s == S_ACTIVE) && (state_r != S_ACTIVE);
        leave_s = (state_r == S_ACTIVE) && (state_s != S_ACTIVE) && en;
    end

    // Saturating event counter next value; a coincident entry wins over clear.
    always_comb begin
        evcnt_s = evcnt_r;
        if (enter_s && clear) begin
            evcnt_s = EV_ONE;
        end else if (enter_s) begin
            if (evcnt_r == EV_MAX) begin
                evcnt_s = evcnt_r;
            end else begin
                evcnt_s = evcnt_r + EV_ONE;
            end
        end else if (clear) begin
            evcnt_s = EV_ZERO;
        end else begin
            evcnt_s = evcnt_r;
        end
    end

    // FSM state, hold counter and registered outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= S_IDLE;
            cnt_r   <= CNT_ZERO;
            z_r     <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            evcnt_r <= EV_ZERO;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            z_r     <= (state_s == S_ACTIVE);
            rise_r  <= enter_s;
            fall_r  <= leave_s;
            evcnt_r <= evcnt_s;
        end
    end

    assign z     = z_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
    assign evcnt = evcnt_r;

`ifdef LA_NORDET_STICKY_EN
    logic seen_r;

    // Sticky flag: set with each rise, cleared only by clear or reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seen_r <= 1'b0;
        end else if (enter_s) begin
            seen_r <= 1'b1;
        end else if (clear) begin
            seen_r <= 1'b0;
        end else begin
            seen_r <= seen_r;
        end
    end

    assign seen = seen_r;
`else
    assign seen = 1'b0;
`endif

endmodule

// File: tb/tb_la_nordet.sv
// Scoreboard bench for la_nordet: two instances (N=4/HOLD=4/CW=2 and N=1/HOLD=1/CW=3)
// checked against a run-length reference model; honours LA_NORDET_STICKY_EN.
module tb_la_nordet;

    localparam int HA = 4;
    localparam int HB = 1;
    localparam int EVMAX_A = 3;
    localparam int EVMAX_B = 7;

    logic       clk = 1'b0;
    logic       nreset, en, clear;
    logic [3:0] in_a;
    logic [0:0] in_b;
    logic       z_a, rise_a, fall_a, seen_a;
    logic       z_b, rise_b, fall_b, seen_b;
    logic [1:0] evcnt_a;
    logic [2:0] evcnt_b;

    always #5 clk = ~clk;

    la_nordet #(.N(4), .HOLD(HA), .CW(2), .PROP("DEFAULT")) dut_a (
        .clk(clk), .nreset(nreset), .en(en), .clear(clear), .in(in_a),
        .z(z_a), .rise(rise_a), .fall(fall_a), .evcnt(evcnt_a), .seen(seen_a)
    );

    la_nordet #(.N(1), .HOLD(HB), .CW(3), .PROP("DEFAULT")) dut_b (
        .clk(clk), .nreset(nreset), .en(en), .clear(clear), .in(in_b),
        .z(z_b), .rise(rise_b), .fall(fall_b), .evcnt(evcnt_b), .seen(seen_b)
    );

    typedef struct packed {
        logic       z;
        logic       rise;
        logic       fall;
        logic [7:0] ev;
        logic       seen;
    } obs_t;

    obs_t qa[$];
    obs_t qb[$];
    obs_t ea, eb;
    int   checks = 0;
    int   errors = 0;

    // Reference model: z is high once en&NOR has held for at least HOLD consecutive edges.
    int         run_a, run_b, ev_a, ev_b;
    logic [3:0] mq_a;
    logic       mq_b, mz_a, mz_b, ms_a, ms_b;

    function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void mstep(input bit raw, input int hold, input int evmax,
                                  input logic e, input logic c,
                                  inout int run, inout logic z, inout int ev, inout logic s,
                                  output obs_t o);
        logic zn;
        run = (e && raw) ? ((run < hold) ? run + 1 : hold) : 0;
        zn = (run >= hold);
        o.z    = zn;
        o.rise = zn && !z;
        o.fall = !zn && z && e;
        if (c) begin
            ev = 0;
            s  = 1'b0;
        end
        if (o.rise) begin
            ev = (ev < evmax) ? ev + 1 : evmax;
            s  = 1'b1;
        end
        z = zn;
        o.ev = 8'(ev);
`ifdef LA_NORDET_STICKY_EN
        o.seen = s;
`else
        o.seen = 1'b0;
`endif
    endfunction

    function automatic void mreset();
        run_a = 0; run_b = 0; ev_a = 0; ev_b = 0;
        mq_a = 4'hF; mq_b = 1'b1;
        mz_a = 1'b0; mz_b = 1'b0; ms_a = 1'b0; ms_b = 1'b0;
    endfunction

    task automatic cyc(input logic [3:0] ia, input logic ib, input logic e,
                       input logic c, input logic r);
        obs_t oa, ob;
        @(posedge clk);
        #4;
        in_a = ia; in_b = ib; en = e; clear = c; nreset = r;
        if (!r) begin
            mreset();
            oa = '0;
            ob = '0;
        end else begin
            mstep(mq_a == 4'd0, HA, EVMAX_A, e, c, run_a, mz_a, ev_a, ms_a, oa);
            mstep(mq_b == 1'b0, HB, EVMAX_B, e, c, run_b, mz_b, ev_b, ms_b, ob);
            mq_a = ia;
            mq_b = ib;
        end
        qa.push_back(oa);
        qb.push_back(ob);
    endtask

    // Monitor: one observation per cycle, compared against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_z",     8'(z_a),     8'(ea.z));
                chk("a_rise",  8'(rise_a),  8'(ea.rise));
                chk("a_fall",  8'(fall_a),  8'(ea.fall));
                chk("a_evcnt", 8'(evcnt_a), ea.ev);
                chk("a_seen",  8'(seen_a),  8'(ea.seen));
                chk("b_z",     8'(z_b),     8'(eb.z));
                chk("b_rise",  8'(rise_b),  8'(eb.rise));
                chk("b_fall",  8'(fall_b),  8'(eb.fall));
                chk("b_evcnt", 8'(evcnt_b), eb.ev);
                chk("b_seen",  8'(seen_b),  8'(eb.seen));
            end
        end
    end

    initial begin
        nreset = 1'b0; en = 1'b1; clear = 1'b0; in_a = 4'd0; in_b = 1'b0;
        mreset();
        // reset held with inputs idle, then release and qualify
        repeat (3) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (8) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        // glitch rejection mid-qualification
        repeat (2) cyc(4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(4'b0010, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (7) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        // deassert via in[3]
        repeat (3) cyc(4'b1000, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (6) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        // enable drop while active
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (7) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        // saturate the 2-bit counter
        repeat (5) begin
            cyc(4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
            repeat (5) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        // clear coincident with the next rise of the HOLD=4 instance
        cyc(4'b0100, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (4) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc(4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (2) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        // reset mid-qualification
        cyc(4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (2) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (7) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        // randomized traffic biased toward idle inputs
        repeat (2000) begin
            cyc(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
                ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0);
        end
        repeat (2) cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        chk("drain", 8'(qa.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/la_nordet.md
# la_nordet

Registered, parametrised N-input NOR detector with hold-time qualification, edge pulses and a saturating event counter. It asserts `z` only after every input has been low for `HOLD` consecutive sampled cycles, and deasserts `z` promptly when any input goes high. It is used wherever a bare combinational NOR would pass glitches into control logic: all-idle detection, quiescence checks and low-power entry gating.

## Interface
Parameters:
- `N`, 4: number of inputs; legal range N ≥ 1.
- `HOLD`, 4: consecutive cycles the NOR condition must hold before `z` asserts; legal range 1 ≤ HOLD ≤ 65535.
- `CW`, 8: width of the event counter; legal range CW ≥ 1.
- `PROP`, "DEFAULT": implementation property string; it has no functional effect.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `nreset`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: detector enable.
- `clear`, input, 1: synchronous clear of `evcnt` and `seen`.
- `in`, input, N: inputs to be NOR-reduced.
- `z`, output, 1: qualified NOR result.
- `rise`, output, 1: one-cycle pulse on the first cycle of `z`=1.
- `fall`, output, 1: one-cycle pulse on the first cycle of `z`=0 after a qualified period.
- `evcnt`, output, CW: saturating count of `rise` events.
- `seen`, output, 1: sticky flag; see Configuration.

## Operation
- **Input register:** `in_q` samples `in` on every edge, independent of `en`. Reset value is all-ones, so nothing qualifies straight out of reset. `raw = ~|in_q`.
- **State machine:** states IDLE, QUAL and ACTIVE, plus a hold counter of $clog2(HOLD+1) bits. `z` = (state == ACTIVE).
- **IDLE:**
  - `en` & `raw`: go to ACTIVE if HOLD==1; otherwise go to QUAL with cnt=1.
  - Otherwise: stay in IDLE with cnt=0.
- **QUAL:**
  - `en` & `raw` & cnt==HOLD-1: go to ACTIVE.
  - `en` & `raw` otherwise: cnt+1.
  - `!raw`: go to IDLE with cnt=0.
- **ACTIVE:** `!raw` goes to IDLE with cnt=0; otherwise stay in ACTIVE.
- **Enable:**
  - `en`=0 in any state forces IDLE with cnt=0 on the next edge.
  - A `fall` pulse is not generated when ACTIVE is left because of `en`=0; `z` still drops.
- **`rise`:** registered; high in the first cycle `z` is 1.
- **`fall`:** registered; high in the first cycle `z` is 0 after ACTIVE is left with `en`=1.
- **`evcnt`:** increments on every IDLE/QUAL to ACTIVE transition and saturates at 2^CW-1 without wrapping.
- **`clear` with a simultaneous transition into ACTIVE:** `evcnt` becomes 1 and `seen` becomes 1 (set wins).
- **Reset values:** `z`=0, `rise`=0, `fall`=0, `evcnt`=0, `seen`=0, state=IDLE, cnt=0, `in_q`=all-ones.
- **Reset mid-qualification:** all state is discarded; qualification restarts from scratch after reset deasserts.

## Timing
- **Assertion latency:** `in` all-zero and stable before edge k. `in_q`=0 after edge k; `z`=1 and `rise`=1 after edge k+HOLD.
- **Deassertion latency:** any `in` bit high before edge k. `in_q`≠0 after edge k; `z`=0 and `fall`=1 after edge k+1.
- **Minimum valid pulse:** a high pulse of one cycle on any input resets qualification, so the full HOLD cycles restart.
- **Pulse width:** `rise` and `fall` are exactly one cycle wide and never high together.
- **Counter and flag timing:** `evcnt` and `seen` update on the same edge that sets `z`.
- **Reset timing:** `nreset` asynchronously forces all reset values; release is synchronous to `clk` by system convention.

## Configuration
- Macro `LA_NORDET_STICKY_EN`.
- **Defined:** `seen` is a register set on `rise` and cleared only by `clear` or reset.
- **Undefined:** `seen` is tied to 0, and its register and set logic are not built.
- All other behaviour is identical in both builds.

## Test plan
- **Reset:** N=4, HOLD=4; hold `nreset`=0 with `in`=0. Then expect all outputs 0 while reset is held. After release: `z` stays 0 until 5 edges have passed; `rise` pulses once; `evcnt`=1.
- **Glitch reject:** HOLD=4, `in`=0; after 3 qualifying edges, set `in`=4'b0010 for 1 cycle, then back to 0. Then expect `z`=0 throughout; `z` asserts 4 edges after `in_q` returns to 0.
- **Deassert:** with `z`=1, set `in`[3]=1. Then expect `z`=0 and `fall`=1 exactly 2 edges later; `rise` stays 0.
- **Enable drop:** with `z`=1, set `en`=0 for 1 cycle. Then expect `z`=0 with no `fall` pulse; after `en`=1, `z` re-asserts HOLD edges later and `evcnt` increments.
- **Saturation and clear:** CW=2; toggle to produce 5 `rise` events. Then expect `evcnt`=3 to stick. `clear` coincident with the next `rise` gives `evcnt`=1 and `seen`=1.
- **Corner build and macro:** HOLD=1, N=1, with and without `LA_NORDET_STICKY_EN`. Then expect `z` 2 edges after `in` falls. `seen` tracks `rise` when the macro is defined and is constant 0 when it is not.
